// File: rtl/lcd_ctrl.sv
// HD44780-style character-LCD write controller.
// Single-cycle LSU write strobes are queued in a small FIFO and replayed onto
// the LCD pins with setup / enable-pulse / hold / execution timing, so that
// software only needs to poll o_busy / o_full.
//
// Write handshake: i_wr_vld is a one-cycle strobe with no ready return path.
// A strobe is accepted when the FIFO is not full at that edge (o_full low).
// A strobe seen while full is dropped and latches the sticky o_ovf flag.
module lcd_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int INIT_CYC      = 750000,
    parameter int SETUP_CYC     = 3,
    parameter int EN_HIGH_CYC   = 12,
    parameter int HOLD_CYC      = 1,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_wr_vld,
    input  logic                          i_wr_rs,
    input  logic [7:0]                    i_wr_data,
    input  logic                          i_lcd_on,
    output logic                          o_busy,
    output logic                          o_full,
    output logic                          o_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_lcd_on,
    output logic                          o_lcd_rs,
    output logic                          o_lcd_rw,
    output logic                          o_lcd_en,
    output logic [7:0]                    o_lcd_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Down-counter reload values (each timed state lasts N cycles).
    localparam logic [31:0] INIT_LD  = 32'(INIT_CYC - 1);
    localparam logic [31:0] SETUP_LD = 32'(SETUP_CYC - 1);
    localparam logic [31:0] EN_LD    = 32'(EN_HIGH_CYC - 1);
    localparam logic [31:0] HOLD_LD  = 32'(HOLD_CYC - 1);
    localparam logic [31:0] EXEC_LD  = 32'(EXEC_CYC - 1);
    localparam logic [31:0] LONG_LD  = 32'(LONG_EXEC_CYC - 1);

    typedef enum logic [2:0] {
        S_INIT_WAIT = 3'd0,
        S_IDLE      = 3'd1,
        S_SETUP     = 3'd2,
        S_EN_HIGH   = 3'd3,
        S_HOLD      = 3'd4,
        S_EXEC      = 3'd5
    } state_t;

    state_t          r_state;
    logic [31:0]     r_cnt;
    logic            r_rs;
    logic [7:0]      r_data;
    logic            r_en;
    logic            r_lcd_on;
    logic            r_ovf;

    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [8:0]      w_head;
    logic            w_long;

    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_push = i_wr_vld && !w_full;
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    assign w_head = r_mem[r_rptr];

    // Clear and return-home (0x01..0x03 as commands) need the long execution time.
    assign w_long = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_wr_rs, i_wr_data};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A strobe while full is lost even if a pop frees a slot this cycle.
            if (i_wr_vld && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Pin-timing sequencer with registered RS / DATA / EN outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_INIT_WAIT;
            r_cnt   <= INIT_LD;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_en    <= 1'b0;
        end else begin
            case (r_state)
                S_INIT_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_IDLE: begin
                    if (w_pop) begin
                        r_rs    <= w_head[8];
                        r_data  <= w_head[7:0];
                        r_cnt   <= SETUP_LD;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b1;
                        r_cnt   <= EN_LD;
                        r_state <= S_EN_HIGH;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_EN_HIGH: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b0;
                        r_cnt   <= HOLD_LD;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= w_long ? LONG_LD : EXEC_LD;
                        r_state <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_cnt   <= INIT_LD;
                    r_state <= S_INIT_WAIT;
                end
            endcase
        end
    end

    // Registered panel-enable level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lcd_on <= 1'b0;
        end else begin
            r_lcd_on <= i_lcd_on;
        end
    end

    assign o_busy     = (r_state != S_IDLE) || (r_count != '0);
    assign o_full     = w_full;
    assign o_ovf      = r_ovf;
    assign o_level    = r_count;
    assign o_lcd_on   = r_lcd_on;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_en;
    assign o_lcd_data = r_data;

endmodule
